universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register/data width; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1, framed-transmit bit order (1 = MSB first, 0 = LSB first).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 Port en  input  1  clock enable for register and FSM.
REQ-006 Port mode  input  3  operation select, honoured in IDLE only.
REQ-007 Port d  input  WIDTH  parallel load data.
REQ-008 Port sin  input  1  serial input bit.
REQ-009 Port start  input  1  begin framed serial transfer.
REQ-010 Port q  output  WIDTH  register contents.
REQ-011 Port sout  output  1  serial output bit.
REQ-012 Port busy  output  1  high while a framed transfer is shifting.
REQ-013 Port done  output  1  one-cycle pulse at end of framed transfer.

Function
REQ-014 Modes SHALL be: 000 hold; 001 parallel load q<=d; 010 shift left, sin into LSB; 011 shift right, sin into MSB; 100 rotate left; 101 rotate right; 110/111 hold (reserved).
REQ-015 Mode operations SHALL take effect on the rising edge where en=1; latency is one cycle.
REQ-016 sout SHALL be combinational from q: q[WIDTH-1] if MSB_FIRST=1, else q[0].
REQ-017 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-018 IDLE with en=1 and start=1: q<=d, bit counter<=0, next state SHIFT; start SHALL override mode.
REQ-019 SHIFT: on each edge with en=1, shift toward sout (left if MSB_FIRST=1, else right), sin filling the vacated end; counter increments.
REQ-020 SHIFT SHALL leave to DONE on the edge performing the WIDTH-th shift; q then holds the WIDTH captured sin bits.
REQ-021 DONE SHALL last one enabled cycle, then return to IDLE.
REQ-022 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE).
REQ-023 Bit i of d (transmit order) SHALL appear on sout in the i-th cycle after the start edge, i = 0..WIDTH-1.
REQ-024 mode and start SHALL be ignored in SHIFT and DONE.
REQ-025 en=0 SHALL freeze q, state and counter in every state; done SHALL stay high if frozen in DONE.
REQ-026 Counter width SHALL be clog2(WIDTH+1); no wrap beyond WIDTH.

Reset
REQ-027 rst=1 SHALL immediately force q=0, counter=0, state=IDLE, so busy=0, done=0, sout=0, including mid-transfer.
REQ-028 The first operation SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-029 Mode encodings and FSM state enumeration SHALL live in shared package shift_reg_pkg.
REQ-030 No sub-module; register, counter and FSM SHALL reside in one module.

Verification (WIDTH=4, MSB_FIRST=1 unless stated)
REQ-031 rst=1 then mode=001 d=1010 en=1, one edge -> q=1010.
REQ-032 q=1010, mode=010 sin=1, one edge -> q=0101; then mode=101, one edge -> q=1010.
REQ-033 d=1010 start=1, sin sequence 0,0,1,0 -> sout 1,0,1,0 over four cycles, busy high for 4 cycles, done one pulse, final q=0010.
REQ-034 Same transfer with en=0 for two cycles after the second shift -> q, sout and busy held; frame completes two cycles late with identical results.
REQ-035 rst asserted after the second shift -> q=0000, busy=0 immediately; next start runs a full clean frame.
REQ-036 MSB_FIRST=0, d=0011 start -> sout 1,1,0,0; mode=001 asserted during SHIFT -> ignored.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation modes and FSM states.
package shift_reg_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
   localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/universal_shift_reg.sv
// Universal shift register with mode-selected parallel/shift/rotate operations
// and a framed serial transfer (load, shift WIDTH bits out while capturing sin).
module universal_shift_reg
   import shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [ST_W-1:0]  r_state;
   logic [ST_W-1:0]  w_state_nxt;
   logic [WIDTH-1:0] w_shift_tx;

   // Framed shift moves data toward sout; sin fills the vacated end.
   assign w_shift_tx = MSB_FIRST ? {r_q[WIDTH-2:0], sin} : {sin, r_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q     <= '0;
         r_cnt   <= '0;
         r_state <= ST_IDLE;
      end else begin
         r_q     <= w_q_nxt;
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_q_nxt     = r_q;
      w_cnt_nxt   = r_cnt;
      w_state_nxt = r_state;
      if (en) begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_q_nxt     = d;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_SHIFT;
               end else begin
                  case (mode)
                     MODE_HOLD: w_q_nxt = r_q;
                     MODE_LOAD: w_q_nxt = d;
                     MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], sin};
                     MODE_SHR:  w_q_nxt = {sin, r_q[WIDTH-1:1]};
                     MODE_ROL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                     MODE_ROR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                     default:   w_q_nxt = r_q;
                  endcase
               end
            end
            ST_SHIFT: begin
               w_q_nxt   = w_shift_tx;
               w_cnt_nxt = r_cnt + CW'(1);
               // The edge doing the WIDTH-th shift ends the frame; counter stops at WIDTH.
               if (r_cnt == CW'(WIDTH - 1)) begin
                  w_state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign q    = r_q;
   assign sout = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];
   assign busy = (r_state == ST_SHIFT);
   assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench: two instances (MSB-first and LSB-first) on shared inputs,
// compared every cycle against an arithmetic model, plus directed literal scenarios.
module tb_universal_shift_reg;

   localparam int unsigned W   = 4;
   localparam int          MOD = 1 << W;

   logic       clk;
   logic       rst;
   logic       en;
   logic [2:0] mode;
   logic [W-1:0] d;
   logic       sin;
   logic       start;

   logic [W-1:0] w_q [2];
   logic         w_sout [2];
   logic         w_busy [2];
   logic         w_done [2];

   int n_checks;
   int n_fail;

   // Model: register value as an integer, shifts left in the frame, done flag.
   int m_q    [2];
   int m_left [2];
   bit m_done [2];

   universal_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin), .start(start),
      .q(w_q[0]), .sout(w_sout[0]), .busy(w_busy[0]), .done(w_done[0])
   );

   universal_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin), .start(start),
      .q(w_q[1]), .sout(w_sout[1]), .busy(w_busy[1]), .done(w_done[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_q[k]    = 0;
            m_left[k] = 0;
            m_done[k] = 1'b0;
         end else if (en) begin
            if (m_done[k]) begin
               m_done[k] = 1'b0;
            end else if (m_left[k] > 0) begin
               if (k == 0) m_q[k] = (m_q[k] * 2 + int'(sin)) % MOD;
               else        m_q[k] = m_q[k] / 2 + int'(sin) * (MOD / 2);
               m_left[k] = m_left[k] - 1;
               if (m_left[k] == 0) m_done[k] = 1'b1;
            end else if (start) begin
               m_q[k]    = int'(d);
               m_left[k] = W;
            end else begin
               case (mode)
                  3'd1: m_q[k] = int'(d);
                  3'd2: m_q[k] = (m_q[k] * 2 + int'(sin)) % MOD;
                  3'd3: m_q[k] = m_q[k] / 2 + int'(sin) * (MOD / 2);
                  3'd4: m_q[k] = (m_q[k] * 2 + m_q[k] / (MOD / 2)) % MOD;
                  3'd5: m_q[k] = m_q[k] / 2 + (m_q[k] % 2) * (MOD / 2);
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int exp_sout;
         exp_sout = (k == 0) ? m_q[k] / (MOD / 2) : m_q[k] % 2;
         chk($sformatf("cyc_q%0d", k),    int'(w_q[k]),    m_q[k]);
         chk($sformatf("cyc_sout%0d", k), int'(w_sout[k]), exp_sout);
         chk($sformatf("cyc_busy%0d", k), int'(w_busy[k]), int'(m_left[k] > 0));
         chk($sformatf("cyc_done%0d", k), int'(w_done[k]), int'(m_done[k]));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Framed transfer: sins/exp_sout listed first-bit-in-MSB; optional 2-cycle stall.
   task automatic frame(input int k, input logic [W-1:0] dv, input logic [W-1:0] sins,
                        input logic [W-1:0] exp_sout, input logic [W-1:0] exp_q,
                        input int stall_at, input logic [2:0] mode_during);
      en = 1'b1; d = dv; start = 1'b1; mode = 3'd0;
      step();
      start = 1'b0; mode = mode_during; d = ~dv;
      for (int i = 0; i < W; i++) begin
         if (i == stall_at) begin
            en = 1'b0;
            repeat (2) begin
               step();
               chk("stall_busy", int'(w_busy[k]), 1);
               chk("stall_sout", int'(w_sout[k]), int'(exp_sout[W-1-i]));
            end
            en = 1'b1;
         end
         chk($sformatf("frame_sout%0d", i), int'(w_sout[k]), int'(exp_sout[W-1-i]));
         chk("frame_busy", int'(w_busy[k]), 1);
         sin = sins[W-1-i];
         step();
      end
      chk("frame_done", int'(w_done[k]), 1);
      chk("frame_busy_end", int'(w_busy[k]), 0);
      chk("frame_q", int'(w_q[k]), int'(exp_q));
      chk("model_frame_q", m_q[k], int'(exp_q));
      mode = 3'd0;
      step();
      chk("frame_done_pulse", int'(w_done[k]), 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; en = 1'b0; mode = 3'd0; d = '0; sin = 1'b0; start = 1'b0;
      repeat (2) step();
      chk("rst_q", int'(w_q[0]), 0);
      chk("rst_busy", int'(w_busy[0]), 0);
      chk("rst_done", int'(w_done[0]), 0);
      chk("rst_sout", int'(w_sout[0]), 0);
      rst = 1'b0;

      en = 1'b1; mode = 3'b001; d = 4'b1010;
      step();
      chk("load_q", int'(w_q[0]), 4'b1010);
      chk("model_load_q", m_q[0], 4'b1010);
      mode = 3'b010; sin = 1'b1;
      step();
      chk("shl_q", int'(w_q[0]), 4'b0101);
      chk("model_shl_q", m_q[0], 4'b0101);
      mode = 3'b101;
      step();
      chk("ror_q", int'(w_q[0]), 4'b1010);
      chk("model_ror_q", m_q[0], 4'b1010);
      mode = 3'b000;
      step();

      frame(0, 4'b1010, 4'b0010, 4'b1010, 4'b0010, -1, 3'd0);
      frame(0, 4'b1010, 4'b0010, 4'b1010, 4'b0010, 2, 3'd0);

      // Reset two shifts into a frame, then a clean frame.
      en = 1'b1; d = 4'b1010; start = 1'b1;
      step();
      start = 1'b0; sin = 1'b1;
      repeat (2) step();
      rst = 1'b1;
      #1;
      chk("midrst_q", int'(w_q[0]), 0);
      chk("midrst_busy", int'(w_busy[0]), 0);
      chk("midrst_done", int'(w_done[0]), 0);
      chk("midrst_sout", int'(w_sout[0]), 0);
      step();
      rst = 1'b0;
      frame(0, 4'b0110, 4'b1001, 4'b0110, 4'b1001, -1, 3'd0);

      frame(1, 4'b0011, 4'b1011, 4'b1100, 4'b1101, -1, 3'b001);

      for (int n = 0; n < 1500; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         en    = ($urandom_range(0, 4) != 0);
         mode  = 3'($urandom_range(0, 7));
         d     = W'($urandom());
         sin   = 1'($urandom());
         start = ($urandom_range(0, 3) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
